// File: rtl/serial_tx.sv
// Serial line transmitter: start bit, DATA_W data bits LSB first, stop bit, line idles high.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | line high, waiting for a word
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | even-parity bit (only with SERIAL_TX_PARITY_EN)
  // STOP   | stop bit (1); last cycle accepts the next word
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_W - 1);
  // A one-cycle stop bit is already its own final cycle on entry.
  localparam logic STOP_ONE = (CLKS_PER_BIT == 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic              bit_end;
  logic              take;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  assign bit_end = (cnt == '0);
  assign take    = in_valid && in_ready;
  assign sh_next = shreg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && !bit_end) cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
          if (take) begin
            state    <= START;
            cnt      <= CNT_RELOAD;
            shreg    <= in_data;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par      <= ^in_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            idx    <= '0;
            cnt    <= CNT_RELOAD;
            tx_out <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= CNT_RELOAD;
            if (idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= par;
`else
              state    <= STOP;
              tx_out   <= 1'b1;
              done     <= STOP_ONE;
              in_ready <= STOP_ONE;
`endif
            end else begin
              idx    <= idx + 1'b1;
              shreg  <= sh_next;
              tx_out <= sh_next[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            cnt      <= CNT_RELOAD;
            tx_out   <= 1'b1;
            done     <= STOP_ONE;
            in_ready <= STOP_ONE;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (take) begin
              state    <= START;
              cnt      <= CNT_RELOAD;
              shreg    <= in_data;
              tx_out   <= 1'b0;
              in_ready <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
              par      <= ^in_data;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == CW'(1)) begin
            done     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected line frames, monitors check them at each done pulse.
module tb_serial_tx;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] E_A5 = 11'b101_0100_1010;
  localparam logic [10:0] E_00 = 11'b100_0000_0000;
  localparam logic [10:0] E_FF = 11'b101_1111_1110;
  localparam logic [10:0] E_01 = 11'b110_0000_0010;
  localparam logic [10:0] E_81 = 11'b101_0000_0010;
`else
  localparam int FB = 10;
  localparam logic [10:0] E_A5 = 11'b0_11_0100_1010;
  localparam logic [10:0] E_00 = 11'b0_10_0000_0000;
  localparam logic [10:0] E_FF = 11'b0_11_1111_1110;
  localparam logic [10:0] E_01 = 11'b0_10_0000_0010;
  localparam logic [10:0] E_81 = 11'b0_11_0000_0010;
`endif

  logic clk, rst;
  logic [7:0] in_data, in_data1;
  logic in_valid, in_ready, tx_out, busy, done;
  logic in_valid1, in_ready1, tx_out1, busy1, done1;

  int errors = 0, checks = 0, cyc = 0;
  int n_done = 0, n_done1 = 0, last_done = 0, prev_done = 0, tx_cyc = 0;
  logic [10:0] exp_q[$], exp1_q[$];

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit frame_match(logic [63:0] got, int n, logic [10:0] e, int cpb);
    if (n != FB * cpb) return 1'b0;
    for (int i = 0; i < n; i++)
      if (got[i] !== e[i / cpb]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor for the CLKS_PER_BIT=4 instance
  logic [63:0] got0;
  int n0 = 0;
  always @(negedge clk) begin
    if (!busy) begin
      if (done) begin
        checks++; errors++;
        $display("FAIL done_idle: got done=1 required done=0 while idle");
      end
      n0 = 0;
    end else begin
      if (n0 < 64) got0[n0] = tx_out;
      n0++;
      if (done) begin
        n_done++;
        prev_done = last_done;
        last_done = cyc;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_at_done: got %b required 1", in_ready);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got unexpected frame %h len %0d, required none", got0, n0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          if (!frame_match(got0, n0, e, CPB)) begin
            errors++;
            $display("FAIL frame: got %h len %0d, required bits %b len %0d", got0, n0, e, FB * CPB);
          end
        end
        n0 = 0;
      end
    end
  end

  // Monitor for the CLKS_PER_BIT=1 instance
  logic [63:0] got1;
  int n1 = 0;
  always @(negedge clk) begin
    if (!busy1) begin
      n1 = 0;
    end else begin
      if (n1 < 64) got1[n1] = tx_out1;
      n1++;
      if (done1) begin
        n_done1++;
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL frame1: got unexpected frame %h len %0d, required none", got1, n1);
        end else begin
          logic [10:0] e;
          e = exp1_q.pop_front();
          if (!frame_match(got1, n1, e, 1)) begin
            errors++;
            $display("FAIL frame1: got %h len %0d, required bits %b len %0d", got1, n1, e, FB);
          end
        end
        n1 = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] e, input bit push);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    tx_cyc   = cyc;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == budget) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx_out, 1); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    // single frame
    send(8'hA5, E_A5, 1);
    repeat (5) @(negedge clk);
    chk("mid_ready", in_ready, 0);
    chk("mid_busy", busy, 1);
    wait_idle(80);
    chk("frame_len", last_done - tx_cyc, FB * CPB - 1);

    // back-to-back
    @(negedge clk);
    in_data = 8'h00; in_valid = 1'b1; exp_q.push_back(E_00);
    @(posedge clk); #1;
    in_data = 8'hFF; exp_q.push_back(E_FF);
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("b2b_ready_seen", (k < 80), 1);
    chk("b2b_done1", done, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start_tx", tx_out, 0);
    chk("b2b_start_busy", busy, 1);
    wait_idle(80);
    chk("b2b_spacing", last_done - prev_done, FB * CPB);

    // valid pulsed while busy is ignored
    send(8'hA5, E_A5, 1);
    repeat (10) @(negedge clk);
    chk("ign_ready", in_ready, 0);
    in_data = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(80);
    repeat (50) @(negedge clk);
    chk("ign_idle", busy, 0);

    // mid-frame reset at cycle 15
    send(8'h3C, 11'h0, 0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx_out, 1); chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1); chk("abort_done", done, 0);
    repeat (50) @(negedge clk);
    chk("abort_no_resume", busy, 0);

    // reset beats a simultaneous transfer
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hF0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstpri_busy", busy, 0); chk("rstpri_tx", tx_out, 1);
    repeat (50) @(negedge clk);
    chk("rstpri_idle", busy, 0);

    send(8'h01, E_01, 1);
    wait_idle(80);
    chk("frame_len_01", last_done - tx_cyc, FB * CPB - 1);

    // minimum rate instance
    @(negedge clk);
    in_data1 = 8'h81; in_valid1 = 1'b1; exp1_q.push_back(E_81);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_data1 = 8'h00;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk("cpb1_finished", (k < 30), 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("queue1_empty", exp1_q.size(), 0);
    chk("done_count", n_done, 5);
    chk("done1_count", n_done1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles each line bit is held (legal range >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, DATA_W bits, the parallel word to transmit.
REQ-006 The block SHALL have port in_valid, input, 1 bit, set when in_data is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit, set when a word can be accepted.
REQ-008 The block SHALL have port tx_out, output, 1 bit, the serial line, which idles high.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a frame is on the line.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse at frame end.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, (PARITY), STOP.
REQ-012 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a shift register at that edge, and later changes to in_data SHALL be ignored.
REQ-013 The line SHALL change on the edge after a transfer: tx_out=0 (start bit); latency transfer-to-start-bit = 1 cycle.
REQ-014 The frame SHALL be: start bit 0, then DATA_W data bits LSB first, then (PARITY), then stop bit 1; each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-015 The bit-cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide (minimum 1) and reload at every bit boundary; the bit index SHALL count 0..DATA_W-1 and leave DATA at index DATA_W-1 on the last cycle of that bit.
REQ-016 in_ready SHALL be high in IDLE and during the final cycle of STOP, and low otherwise.
REQ-017 A transfer in the final STOP cycle SHALL go straight to START, so frames run back-to-back with no idle cycle between them.
REQ-018 done SHALL be high for exactly the final cycle of STOP, whether or not a new word is accepted in that cycle.
REQ-019 busy SHALL be high in every state except IDLE.
REQ-020 in_valid SHALL be ignored while in_ready=0, and no word SHALL be lost or queued.
REQ-021 With CLKS_PER_BIT=1 each bit SHALL last exactly 1 cycle, and the frame length SHALL be DATA_W+2 cycles.

Reset
REQ-022 While rst=1 at a rising edge, the next state SHALL be IDLE with tx_out=1, busy=0, done=0, in_ready=1, and the counters and shift register cleared.
REQ-023 A reset in the middle of a frame SHALL abort the frame; tx_out SHALL be 1 from the cycle after that edge; no done pulse SHALL be issued, and the aborted word SHALL not be resumed.
REQ-024 rst SHALL take priority over a simultaneous transfer; the offered word SHALL be discarded.

Configuration
REQ-025 The macro SERIAL_TX_PARITY_EN, when defined, SHALL insert a PARITY state between DATA and STOP that sends the even-parity bit (XOR of the DATA_W bits) for CLKS_PER_BIT cycles, making the frame (DATA_W+3)*CLKS_PER_BIT cycles long.
REQ-026 With SERIAL_TX_PARITY_EN undefined, the block SHALL have no PARITY state, and the frame SHALL be (DATA_W+2)*CLKS_PER_BIT cycles long.

Verification
REQ-027 Single frame: defaults, transfer 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); done high on cycle 40 only; busy high for cycles 1-40.
REQ-028 Back-to-back: 0x00 then 0xFF held valid continuously -> second start bit follows the first stop bit with no idle cycle; exactly 2 done pulses 40 cycles apart.
REQ-029 Parity: SERIAL_TX_PARITY_EN defined, send 0x01 -> parity bit 1, 44-cycle frame; send 0xA5 -> parity bit 0.
REQ-030 Mid-frame reset: rst=1 for one edge at cycle 15 of a 0x3C frame -> tx_out=1, busy=0, in_ready=1 on the next cycle; no done pulse.
REQ-031 Minimum rate: CLKS_PER_BIT=1, send 0x81 -> tx_out = 0,1,0,0,0,0,0,0,1,1 on 10 consecutive cycles.
REQ-032 Ignored valid: in_valid pulsed with 0x55 while busy -> no effect on the frame in progress; that word is never transmitted.
